// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and port-slicing helper for the register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    typedef enum logic [0:0] {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

    // LSB position of port k in a packed vector of w-bit fields.
    function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard with set-over-clear priority and per-port read mux.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter int unsigned NUM_RD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q, busy_d;

    // Next busy vector: flush wins, then clear, then set (new producer supersedes).
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (clr_en) busy_d[clr_addr] = 1'b0;
            if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
        end
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          kill;
        assign a = rd_addr[port_lsb(k, AW) +: AW];
        // A same-cycle writeback to this address delivers the value via bypass,
        // unless an issue to the same address is re-marking it pending.
        assign kill = clr_en && (clr_addr == a) && !(set_en && (set_addr == a));
        assign rd_busy[k] = busy_q[a] & ~kill;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with bypass, hardwired x0, clear sweep and scoreboard.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter int unsigned NUM_RD = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    output logic                   rdy,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr
);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic             ready;
    logic             sweep_we;
    logic             wr_fire;
    logic [NUM_RD-1:0] sb_busy;

    // State and sweep index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next-state logic: sweep every register once, clr restarts the sweep.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            RF_CLEAR: begin
                if (clr) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d   = RF_READY;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            RF_READY: begin
                if (clr) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        ready    = (state_q == RF_READY);
        rdy      = ready;
        sweep_we = (state_q == RF_CLEAR);
        // A write coinciding with a clr request is dropped.
        wr_fire  = ready && !clr && wr_en && (wr_addr != '0);
    end

    // Storage array: no reset, contents are defined by the sweep.
    always_ff @(posedge clk) begin
        if (sweep_we)     regs_q[clr_idx_q] <= '0;
        else if (wr_fire) regs_q[wr_addr]   <= wr_data;
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (clr),
        .set_en   (ready && iss_en),
        .set_addr (iss_addr),
        .clr_en   (ready && wr_en),
        .clr_addr (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (sb_busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          byp;
        assign a   = rd_addr[port_lsb(k, AW) +: AW];
        assign byp = ready && wr_en && (wr_addr == a);
        assign rd_data[port_lsb(k, XLEN) +: XLEN] =
            (!ready || (a == '0)) ? '0 : (byp ? wr_data : regs_q[a]);
        assign rd_busy[k] = ready & sb_busy[k];
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (XLEN=32, NREGS=32, NUM_RD=4).
module tb_reg_file_mp;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned NUM_RD = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clr;
    logic                   rdy;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;

    int n_vec = 0;
    int n_err = 0;

    reg_file_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .rdy      (rdy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and move 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    function automatic logic [31:0] dat(input int k);
        return rd_data[k*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] bsy(input int k);
        return 32'(rd_busy[k]);
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
        set_rd(5'd1, 5'd2, 5'd3, 5'd4);
        #1;
        chk("reset_rdy", 32'(rdy), 32'h0);
        chk("reset_data0", dat(0), 32'h0);
        chk("reset_busy", 32'(rd_busy), 32'h0);

        // Release reset away from the edge; rdy must rise on the 32nd edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("rise_rdy_%0d", k), 32'(rdy), 32'(k == 32));
        end

        // Every register reads zero after the sweep.
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(i), 5'(i), 5'(i));
            #1;
            chk($sformatf("swept_x%0d", i), dat(0) | dat(3), 32'h0);
        end

        // Plain write and x0 behaviour.
        wr(5'd4, 32'h0000000A);
        set_rd(5'd4, 5'd0, 5'd0, 5'd0);
        #1;
        chk("rd_x4", dat(0), 32'h0000000A);
        chk("rd_x0", dat(1), 32'h0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFC;
        #1;
        chk("x0_no_bypass", dat(1), 32'h0);
        step();
        wr_en = 1'b0;
        #1;
        chk("x0_after_write", dat(1), 32'h0);

        // Combinational bypass, then the stored value.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        set_rd(5'd3, 5'd4, 5'd0, 5'd0);
        #1;
        chk("bypass_x3", dat(0), 32'hDEADBEEF);
        chk("bypass_other", dat(1), 32'h0000000A);
        step();
        wr_en = 1'b0;
        #1;
        chk("stored_x3", dat(0), 32'hDEADBEEF);

        // Scoreboard set.
        set_rd(5'd7, 5'd9, 5'd10, 5'd0);
        iss_en = 1'b1; iss_addr = 5'd7;
        #1;
        chk("busy7_before", bsy(0), 32'h0);
        step();
        iss_en = 1'b0;
        #1;
        chk("busy7_set", bsy(0), 32'h1);
        // Same address issue + writeback: set wins, no bypass exception.
        iss_en = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5;
        #1;
        chk("busy7_same_comb", bsy(0), 32'h1);
        chk("data7_bypass", dat(0), 32'h5);
        step();
        iss_en = 1'b0; wr_en = 1'b0;
        #1;
        chk("busy7_same_held", bsy(0), 32'h1);
        // Writeback alone: bypassed value reads not-busy, then clears.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h6;
        #1;
        chk("busy7_wb_comb", bsy(0), 32'h0);
        step();
        wr_en = 1'b0;
        #1;
        chk("busy7_cleared", bsy(0), 32'h0);
        // Different addresses in the same cycle both take effect.
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        iss_addr = 5'd10; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        step();
        iss_en = 1'b0; wr_en = 1'b0;
        #1;
        chk("busy9_cleared", bsy(1), 32'h0);
        chk("busy10_set", bsy(2), 32'h1);
        // x0 is never busy.
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        iss_en = 1'b0;
        #1;
        chk("busy0_never", bsy(3), 32'h0);

        // Soft clear: x31 and busy bits wiped, writes/issues ignored during the sweep.
        wr(5'd31, 32'h0000000C);
        set_rd(5'd31, 5'd10, 5'd5, 5'd4);
        #1;
        chk("x31_written", dat(0), 32'h0000000C);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h55; iss_en = 1'b1; iss_addr = 5'd5;
            #1;
            if (k == 1) chk("sweep_data_forced", dat(0), 32'h0);
            if (k == 1) chk("sweep_busy_forced", 32'(rd_busy), 32'h0);
            step();
            wr_en = 1'b0; iss_en = 1'b0;
            chk($sformatf("clr_rdy_%0d", k), 32'(rdy), 32'(k == 32));
        end
        #1;
        chk("x31_cleared", dat(0), 32'h0);
        chk("x4_cleared", dat(3), 32'h0);
        chk("busy_all_clear", 32'(rd_busy), 32'h0);

        // Reset mid-sweep at clr_idx=10.
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", 32'(rdy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("midrst_rdy_%0d", k), 32'(rdy), 32'(k == 32));
        end

        // Four independent ports.
        wr(5'd1, 32'h11111111);
        wr(5'd2, 32'h22222222);
        wr(5'd3, 32'h33333333);
        set_rd(5'd3, 5'd1, 5'd0, 5'd2);
        #1;
        chk("p0_x3", dat(0), 32'h33333333);
        chk("p1_x1", dat(1), 32'h11111111);
        chk("p2_x0", dat(2), 32'h0);
        chk("p3_x2", dat(3), 32'h22222222);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-write, two-read integer register file for the RISC-V core.
- Adds N combinational read ports, write-to-read bypass, and a hardwired-zero x0.
- Clears all registers through a hardware sequencer after reset, with no initial-block preload.
- Holds a per-register busy scoreboard that decode uses for hazard detection.
- Sits between decode/issue (read and issue ports) and writeback (write port).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREGS), register address width (derived; do not override)
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous soft-clear request; restarts the clear sequence
rdy  output  1  high when the clear sequence is done and the file is usable
rd_addr  input  NUM_RD*AW  packed read addresses; port k at [k*AW +: AW]
rd_data  output  NUM_RD*XLEN  packed read data; port k at [k*XLEN +: XLEN]
rd_busy  output  NUM_RD  scoreboard busy bit for each read address
wr_en  input  1  writeback enable
wr_addr  input  AW  writeback register index
wr_data  input  XLEN  writeback data
iss_en  input  1  issue enable; marks iss_addr as pending
iss_addr  input  AW  destination register of the issuing instruction

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to CLEAR with clr_idx=0.
  - rdy=0, all busy bits 0.
  - rd_data reads 0 and rd_busy reads 0 on every port.
  - Register contents are don't-care until the sweep overwrites them.
- FSM states: CLEAR and READY.
  - CLEAR: each cycle writes 0 to reg[clr_idx] and increments clr_idx. When clr_idx==NREGS-1 the next state is READY.
  - rdy rises in the NREGS-th cycle after rst_n deasserts. It is registered and equals (state==READY).
  - READY: on clr=1, next state is CLEAR, clr_idx=0, rdy=0 next cycle, busy bits cleared.
  - CLEAR with clr=1: sweep restarts from 0.
- During CLEAR:
  - wr_en and iss_en are ignored.
  - rd_data and rd_busy are forced to 0.
- Write (READY only): on the rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Writes to address 0 are dropped.
- Read: combinational, zero latency.
  - Port k returns 0 if rd_addr_k==0.
  - Otherwise it returns wr_data if wr_en && wr_addr==rd_addr_k && state==READY (bypass).
  - Otherwise it returns reg[rd_addr_k].
- Scoreboard (READY only), updated on the rising edge:
  - iss_en sets busy[iss_addr].
  - wr_en clears busy[wr_addr].
  - Same cycle, same address: set wins, because the new producer supersedes.
  - Same cycle, different addresses: both take effect.
  - Address 0 is never set busy.
- rd_busy_k = busy[rd_addr_k], with no bypass.
  - Exception: if wr_en && wr_addr==rd_addr_k in the same cycle and iss_addr differs, rd_busy_k reads 0 (the value is bypassed).
- Reset mid-sweep restarts at clr_idx=0. clr asserted in the same cycle as wr_en: the write is dropped.
- Width rules: clr_idx is AW bits and wraps only via the explicit transition. No arithmetic on data.

Decomposition:
- Shared package regfile_pkg:
  - default XLEN/NREGS constants
  - state enum {RF_CLEAR, RF_READY}
  - function to slice packed port k
- One sub-module, rf_scoreboard: the NREGS-bit busy vector with set/clear priority, plus its read mux. The storage array, FSM and bypass mux stay in reg_file_mp.

Test Plan:
- Reset release -> rdy=0 for cycles 0..31 and rdy=1 from cycle 32 (NREGS=32). After that, every rd_addr 0..31 reads 32'h0.
- Write x4=32'h0000000A, then read ports 0/1 at x4/x0 next cycle -> 32'h0000000A / 32'h0. Write x0=32'hFFFFFFFC, then read x0 -> 32'h0.
- Same cycle wr_en x3=32'hDEADBEEF and rd_addr0=x3 -> rd_data0=32'hDEADBEEF combinationally. The next cycle, with wr_en=0, also reads 32'hDEADBEEF.
- Scoreboard:
  - iss_en x7 -> rd_busy=1 for x7 next cycle.
  - Same-cycle iss_en x7 and wr_en x7 -> stays busy.
  - Then wr_en x7 alone -> busy=0.
  - iss_en x0 -> never busy.
- Write x31=32'h0000000C, assert clr for 1 cycle -> rdy=0 for 32 cycles. x31 reads 0 after rdy returns and all busy bits are 0. wr_en during the sweep has no effect.
- Assert rst_n low mid-sweep at clr_idx=10 -> the sweep restarts and rdy rises 32 cycles after release. NUM_RD=4 run: all four ports read independent addresses correctly.
